// File: rtl/cram_pingpong.sv
// Two-bank complex RAM for FFT stages: reads come from the active bank, writes go to the other one.
// Optional feature macro CRAM_BITREV_EN adds bitrev_wr for bit-reversed write addressing.
module cram_pingpong #(
  parameter int N         = 32,
  parameter int WORD_SIZE = 16,
  parameter int STAGES    = $clog2(N)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(N)-1:0]          rd_addr1,
  input  logic [$clog2(N)-1:0]          rd_addr2,
  input  logic                          rd_en,
  input  logic [$clog2(N)-1:0]          wr_addr1,
  input  logic [$clog2(N)-1:0]          wr_addr2,
  input  logic                          wr_en,
  input  logic [2*WORD_SIZE-1:0]        in1,
  input  logic [2*WORD_SIZE-1:0]        in2,
  input  logic                          swap,
`ifdef CRAM_BITREV_EN
  input  logic                          bitrev_wr,
`endif
  output logic [2*WORD_SIZE-1:0]        out1,
  output logic [2*WORD_SIZE-1:0]        out2,
  output logic                          o_valid,
  output logic                          wr_complete,
  output logic                          bank_sel,
  output logic [$clog2(STAGES):0]       stage,
  output logic                          frame_done
);

  localparam int AW = $clog2(N);
  localparam int DW = 2 * WORD_SIZE;
  localparam int SW = $clog2(STAGES) + 1;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  logic [DW-1:0] mem [2][N];
  logic [AW-1:0] wa1_p0, wa2_p0;
  logic          vld_p1;
  logic          wr_done_p1;

  // Stage 0: write address decode
`ifdef CRAM_BITREV_EN
  assign wa1_p0 = bitrev_wr ? bitrev(wr_addr1) : wr_addr1;
  assign wa2_p0 = bitrev_wr ? bitrev(wr_addr2) : wr_addr2;
`else
  assign wa1_p0 = wr_addr1;
  assign wa2_p0 = wr_addr2;
`endif

  // Stage 0 -> 1: inactive-bank write; port 2 is assigned last so it wins on an address clash
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[~bank_sel][wa1_p0] <= in1;
      mem[~bank_sel][wa2_p0] <= in2;
    end
  end

  // Stage 0 -> 1: active-bank read, completion flags and bank/stage sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out1       <= '0;
      out2       <= '0;
      vld_p1     <= 1'b0;
      wr_done_p1 <= 1'b0;
      bank_sel   <= 1'b0;
      stage      <= '0;
      frame_done <= 1'b0;
    end else begin
      vld_p1     <= rd_en;
      wr_done_p1 <= wr_en;
      frame_done <= 1'b0;
      if (rd_en) begin
        out1 <= mem[bank_sel][rd_addr1];
        out2 <= mem[bank_sel][rd_addr2];
      end
      if (swap) begin
        bank_sel <= ~bank_sel;
        if (stage == SW'(STAGES - 1)) begin
          stage      <= '0;
          frame_done <= 1'b1;
        end else begin
          stage <= stage + SW'(1);
        end
      end
    end
  end

  assign o_valid     = vld_p1;
  assign wr_complete = wr_done_p1;

endmodule

// File: tb/tb_cram_pingpong.sv
// Directed bench for cram_pingpong (N=8, WORD_SIZE=16): vector table plus hand-written sequences.
module tb_cram_pingpong;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr1, wr_addr2;
  logic        rd_en, wr_en, swap;
  logic [31:0] in1, in2;
  logic [31:0] out1, out2;
  logic        o_valid, wr_complete, bank_sel, frame_done;
  logic [2:0]  stage;
`ifdef CRAM_BITREV_EN
  logic        bitrev_wr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cram_pingpong #(.N(8), .WORD_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_en(rd_en),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_en(wr_en),
    .in1(in1), .in2(in2), .swap(swap),
`ifdef CRAM_BITREV_EN
    .bitrev_wr(bitrev_wr),
`endif
    .out1(out1), .out2(out2), .o_valid(o_valid), .wr_complete(wr_complete),
    .bank_sel(bank_sel), .stage(stage), .frame_done(frame_done)
  );

  typedef struct {
    logic        rst_n, rd_en, wr_en, swap;
    logic [2:0]  ra1, ra2, wa1, wa2;
    logic [31:0] d1, d2;
    logic [31:0] e_o1, e_o2;
    logic        e_ov, e_wc, e_bs;
    logic [2:0]  e_st;
    logic        e_fd;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; rd_en = v.rd_en; wr_en = v.wr_en; swap = v.swap;
    rd_addr1 = v.ra1; rd_addr2 = v.ra2; wr_addr1 = v.wa1; wr_addr2 = v.wa2;
    in1 = v.d1; in2 = v.d2;
  endtask

  task automatic idle();
    rst_n = 1'b1; rd_en = 1'b0; wr_en = 1'b0; swap = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr1 = '0; wr_addr2 = '0;
    in1 = '0; in2 = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
`ifdef CRAM_BITREV_EN
    bitrev_wr = 1'b0;
`endif
    // fields: rst_n rd_en wr_en swap | ra1 ra2 wa1 wa2 | d1 d2 | e_o1 e_o2 | e_ov e_wc e_bs e_st e_fd
    vecs[0]  = '{0,1,1,1, 1,2,3,4, 32'hFFFF_FFFF,32'hEEEE_EEEE, 32'h0,32'h0, 0,0,0,3'd0,0};
    vecs[1]  = '{0,0,0,0, 0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 0,0,0,3'd0,0};
    vecs[2]  = '{1,0,1,0, 0,0,3,5, 32'h0001_0002,32'h0003_0004, 32'h0,32'h0, 0,1,0,3'd0,0};
    vecs[3]  = '{1,0,0,1, 0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 0,0,1,3'd1,0};
    vecs[4]  = '{1,1,0,0, 3,5,0,0, 32'h0,32'h0, 32'h0001_0002,32'h0003_0004, 1,0,1,3'd1,0};
    vecs[5]  = '{1,0,0,0, 0,0,0,0, 32'h0,32'h0, 32'h0001_0002,32'h0003_0004, 0,0,1,3'd1,0};
    vecs[6]  = '{1,0,1,0, 0,0,2,2, 32'h1234_5678,32'h1234_5678, 32'h0001_0002,32'h0003_0004, 0,1,1,3'd1,0};
    vecs[7]  = '{1,0,0,1, 0,0,0,0, 32'h0,32'h0, 32'h0001_0002,32'h0003_0004, 0,0,0,3'd2,0};
    vecs[8]  = '{1,1,1,0, 2,2,2,2, 32'hAAAA_5555,32'hAAAA_5555, 32'h1234_5678,32'h1234_5678, 1,1,0,3'd2,0};
    vecs[9]  = '{1,0,0,1, 0,0,0,0, 32'h0,32'h0, 32'h1234_5678,32'h1234_5678, 0,0,1,3'd0,1};
    vecs[10] = '{1,1,0,0, 2,2,0,0, 32'h0,32'h0, 32'hAAAA_5555,32'hAAAA_5555, 1,0,1,3'd0,0};
    vecs[11] = '{1,0,1,0, 0,0,6,6, 32'h1111_1111,32'h2222_2222, 32'hAAAA_5555,32'hAAAA_5555, 0,1,1,3'd0,0};
    vecs[12] = '{1,0,0,1, 0,0,0,0, 32'h0,32'h0, 32'hAAAA_5555,32'hAAAA_5555, 0,0,0,3'd1,0};
    vecs[13] = '{1,1,0,0, 6,6,0,0, 32'h0,32'h0, 32'h2222_2222,32'h2222_2222, 1,0,0,3'd1,0};
    vecs[14] = '{0,1,1,0, 6,6,3,3, 32'hDEAD_DEAD,32'hDEAD_DEAD, 32'h0,32'h0, 0,0,0,3'd0,0};
    vecs[15] = '{1,0,0,1, 0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 0,0,1,3'd1,0};
    vecs[16] = '{1,0,0,1, 0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 0,0,0,3'd2,0};
    vecs[17] = '{1,0,0,1, 0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 0,0,1,3'd0,1};
    vecs[18] = '{1,1,0,0, 3,5,0,0, 32'h0,32'h0, 32'h0001_0002,32'h0003_0004, 1,0,1,3'd0,0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.out1", i), out1, vecs[i].e_o1);
      chk($sformatf("v%0d.out2", i), out2, vecs[i].e_o2);
      chk($sformatf("v%0d.o_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].e_ov});
      chk($sformatf("v%0d.wr_complete", i), {31'b0, wr_complete}, {31'b0, vecs[i].e_wc});
      chk($sformatf("v%0d.bank_sel", i), {31'b0, bank_sel}, {31'b0, vecs[i].e_bs});
      chk($sformatf("v%0d.stage", i), {29'b0, stage}, {29'b0, vecs[i].e_st});
      chk($sformatf("v%0d.frame_done", i), {31'b0, frame_done}, {31'b0, vecs[i].e_fd});
    end

    // Write addr 1 into bank 0 (bank_sel=1 now), swap, then read it back
    @(negedge clk);
    idle();
    wr_en = 1'b1; wr_addr1 = 3'd1; wr_addr2 = 3'd1;
    in1 = 32'hBEEF_0001; in2 = 32'hBEEF_0001;
`ifdef CRAM_BITREV_EN
    bitrev_wr = 1'b1;
`endif
    @(posedge clk); #1;
    chk("br.wr_complete", {31'b0, wr_complete}, 32'd1);

    @(negedge clk);
    idle();
`ifdef CRAM_BITREV_EN
    bitrev_wr = 1'b0;
`endif
    swap = 1'b1;
    @(posedge clk); #1;
    chk("br.bank_sel", {31'b0, bank_sel}, 32'd0);
    chk("br.stage", {29'b0, stage}, 32'd1);

    @(negedge clk);
    idle();
    rd_en = 1'b1;
`ifdef CRAM_BITREV_EN
    rd_addr1 = 3'd4; rd_addr2 = 3'd4;
`else
    rd_addr1 = 3'd1; rd_addr2 = 3'd1;
`endif
    @(posedge clk); #1;
    chk("br.out1", out1, 32'hBEEF_0001);
    chk("br.out2", out2, 32'hBEEF_0001);
    chk("br.o_valid", {31'b0, o_valid}, 32'd1);

    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk("hold.o_valid", {31'b0, o_valid}, 32'd0);
    chk("hold.out1", out1, 32'hBEEF_0001);
    chk("hold.wr_complete", {31'b0, wr_complete}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
